mem_stage: RTL and testbench

Memory stage of the five-stage core. Consumes the 80-bit EXE-to-MEM bus, performs byte/half/word loads and stores through a req/ack data-memory port, and emits a 38-bit MEM-to-WB bus. Non-memory results pass through with one-cycle latency, and the block stalls the EXE stage while a memory access is outstanding.

---
 rtl/mem_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage core.
//   Accepts one EXE->MEM bus word per cycle while IDLE. A non-memory op or a
//   misaligned access retires on the next cycle. An aligned load/store moves to
//   BUSY and holds a req/ack data-memory transaction open until the ack.
// Ports:
//   clk, resetn               - rising-edge clock, asynchronous active-low reset
//   exe_valid / exe_ready     - EXE handshake (ready = IDLE, combinational)
//   EXE_MEM_BUS[79:0]         - {through[15:0], alu_data[31:0], out_data[31:0]}
//   dmem_req/we/addr/be/wdata - registered data-memory request, stable until ack
//   dmem_ack, dmem_rdata      - one-cycle completion pulse and load data
//   wb_valid, MEM_WB_BUS[37:0]- retire pulse and {wb_en, wb_dst, wb_data}
//   align_err                 - one-cycle pulse for a misaligned memory op
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    output logic        exe_ready,
    input  logic [79:0] EXE_MEM_BUS,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [37:0] MEM_WB_BUS,
    output logic        align_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access could target.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Sizes 10 and 11 are both word accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    // Little-endian lane extraction with optional sign extension.
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = {{24{sext & b[7]}}, b};
            2'b01:   r = {{16{sext & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Bus field decode
    logic        mem_en_s, mem_we_s, sext_s, wb_en_s;
    logic [1:0]  size_s;
    logic [4:0]  wb_dst_s;
    logic [4:0]  rsvd_unused_s;
    logic [31:0] alu_data_s, out_data_s;

    assign mem_en_s      = EXE_MEM_BUS[79];
    assign mem_we_s      = EXE_MEM_BUS[78];
    assign size_s        = EXE_MEM_BUS[77:76];
    assign sext_s        = EXE_MEM_BUS[75];
    assign wb_en_s       = EXE_MEM_BUS[74];
    assign wb_dst_s      = EXE_MEM_BUS[73:69];
    assign rsvd_unused_s = EXE_MEM_BUS[68:64];
    assign alu_data_s    = EXE_MEM_BUS[63:32];
    assign out_data_s    = EXE_MEM_BUS[31:0];

    state_t      state_r, state_nxt_s;
    logic        req_r, req_nxt_s;
    logic        we_r, we_nxt_s;
    logic [29:0] addr_r, addr_nxt_s;
    logic [3:0]  be_r, be_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic [1:0]  size_r, size_nxt_s;
    logic [1:0]  off_r, off_nxt_s;
    logic        sext_r, sext_nxt_s;
    logic        wb_en_r, wb_en_nxt_s;
    logic [4:0]  wb_dst_r, wb_dst_nxt_s;
    logic        wb_valid_r, wb_valid_nxt_s;
    logic [37:0] wb_bus_r, wb_bus_nxt_s;
    logic        align_err_r, align_err_nxt_s;

    // Next-state and next-output decode for the IDLE/BUSY controller
    always_comb begin
        state_nxt_s     = state_r;
        req_nxt_s       = req_r;
        we_nxt_s        = we_r;
        addr_nxt_s      = addr_r;
        be_nxt_s        = be_r;
        wdata_nxt_s     = wdata_r;
        size_nxt_s      = size_r;
        off_nxt_s       = off_r;
        sext_nxt_s      = sext_r;
        wb_en_nxt_s     = wb_en_r;
        wb_dst_nxt_s    = wb_dst_r;
        wb_valid_nxt_s  = 1'b0;
        wb_bus_nxt_s    = wb_bus_r;
        align_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (exe_valid) begin
                    size_nxt_s   = size_s;
                    off_nxt_s    = alu_data_s[1:0];
                    sext_nxt_s   = sext_s;
                    wb_en_nxt_s  = wb_en_s;
                    wb_dst_nxt_s = wb_dst_s;
                    if (!mem_en_s) begin
                        wb_valid_nxt_s = 1'b1;
                        wb_bus_nxt_s   = {wb_en_s, wb_dst_s, out_data_s};
                    end else if (is_misaligned(size_s, alu_data_s[1:0])) begin
                        align_err_nxt_s = 1'b1;
                        wb_valid_nxt_s  = 1'b1;
                        wb_bus_nxt_s    = {1'b0, wb_dst_s, 32'h0000_0000};
                    end else begin
                        state_nxt_s = ST_BUSY;
                        req_nxt_s   = 1'b1;
                        we_nxt_s    = mem_we_s;
                        addr_nxt_s  = alu_data_s[31:2];
                        be_nxt_s    = calc_be(size_s, alu_data_s[1:0]);
                        wdata_nxt_s = calc_wdata(size_s, out_data_s);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    state_nxt_s    = ST_IDLE;
                    req_nxt_s      = 1'b0;
                    wb_valid_nxt_s = 1'b1;
                    if (we_r) begin
                        wb_bus_nxt_s = {1'b0, wb_dst_r, 32'h0000_0000};
                    end else begin
                        wb_bus_nxt_s = {wb_en_r, wb_dst_r, fmt_load(dmem_rdata, size_r, off_r, sext_r)};
                    end
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 30'd0;
            be_r        <= 4'd0;
            wdata_r     <= 32'd0;
            size_r      <= 2'd0;
            off_r       <= 2'd0;
            sext_r      <= 1'b0;
            wb_en_r     <= 1'b0;
            wb_dst_r    <= 5'd0;
            wb_valid_r  <= 1'b0;
            wb_bus_r    <= 38'd0;
            align_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_r       <= req_nxt_s;
            we_r        <= we_nxt_s;
            addr_r      <= addr_nxt_s;
            be_r        <= be_nxt_s;
            wdata_r     <= wdata_nxt_s;
            size_r      <= size_nxt_s;
            off_r       <= off_nxt_s;
            sext_r      <= sext_nxt_s;
            wb_en_r     <= wb_en_nxt_s;
            wb_dst_r    <= wb_dst_nxt_s;
            wb_valid_r  <= wb_valid_nxt_s;
            wb_bus_r    <= wb_bus_nxt_s;
            align_err_r <= align_err_nxt_s;
        end
    end

    assign exe_ready  = (state_r == ST_IDLE);
    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_be    = be_r;
    assign dmem_wdata = wdata_r;
    assign wb_valid   = wb_valid_r;
    assign MEM_WB_BUS = wb_bus_r;
    assign align_err  = align_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, loads, stores, misalignment
// and reset during an outstanding access, with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        exe_valid;
    logic        exe_ready;
    logic [79:0] EXE_MEM_BUS;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [37:0] MEM_WB_BUS;
    logic        align_err;

    int checks;
    int errors;

    mem_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .exe_valid  (exe_valid),
        .exe_ready  (exe_ready),
        .EXE_MEM_BUS(EXE_MEM_BUS),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .MEM_WB_BUS (MEM_WB_BUS),
        .align_err  (align_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] mk(input logic mem_en, input logic we, input logic [1:0] size,
                                       input logic sext, input logic wb_en, input logic [4:0] dst,
                                       input logic [31:0] alu, input logic [31:0] od);
        return {mem_en, we, size, sext, wb_en, dst, 5'b10101, alu, od};
    endfunction

    // Directed stimulus sequence
    initial begin
        checks      = 0;
        errors      = 0;
        resetn      = 1'b0;
        exe_valid   = 1'b0;
        EXE_MEM_BUS = 80'd0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'd0;
        tick;
        tick;
        chk("rst_req",   64'(dmem_req),   64'(1'b0));
        chk("rst_we",    64'(dmem_we),    64'(1'b0));
        chk("rst_addr",  64'(dmem_addr),  64'(30'd0));
        chk("rst_be",    64'(dmem_be),    64'(4'd0));
        chk("rst_wdata", 64'(dmem_wdata), 64'(32'd0));
        chk("rst_wbv",   64'(wb_valid),   64'(1'b0));
        chk("rst_bus",   64'(MEM_WB_BUS), 64'(38'd0));
        chk("rst_aerr",  64'(align_err),  64'(1'b0));
        resetn = 1'b1;
        #1;
        chk("rst_ready", 64'(exe_ready), 64'(1'b1));

        // Pass-through: three back-to-back non-memory ops
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1, 32'hFFFF_0001, 32'h0000_0011);
        tick;
        chk("pt1_wbv",   64'(wb_valid),   64'(1'b1));
        chk("pt1_bus",   64'(MEM_WB_BUS), 64'({1'b1, 5'd1, 32'h0000_0011}));
        chk("pt1_ready", 64'(exe_ready),  64'(1'b1));
        chk("pt1_req",   64'(dmem_req),   64'(1'b0));
        EXE_MEM_BUS = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd2, 32'h0000_0003, 32'h0000_0022);
        tick;
        chk("pt2_wbv",   64'(wb_valid),   64'(1'b1));
        chk("pt2_bus",   64'(MEM_WB_BUS), 64'({1'b1, 5'd2, 32'h0000_0022}));
        chk("pt2_req",   64'(dmem_req),   64'(1'b0));
        EXE_MEM_BUS = mk(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 5'd3, 32'h0000_0001, 32'h0000_0033);
        tick;
        chk("pt3_wbv",   64'(wb_valid),   64'(1'b1));
        chk("pt3_bus",   64'(MEM_WB_BUS), 64'({1'b1, 5'd3, 32'h0000_0033}));
        chk("pt3_ready", 64'(exe_ready),  64'(1'b1));
        chk("pt3_req",   64'(dmem_req),   64'(1'b0));
        exe_valid = 1'b0;
        tick;
        chk("pt_idle_wbv", 64'(wb_valid), 64'(1'b0));

        // Signed byte load at 0x1003, ack three cycles after the request
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'h0);
        tick;
        exe_valid = 1'b0;
        chk("sb_req",    64'(dmem_req),  64'(1'b1));
        chk("sb_we",     64'(dmem_we),   64'(1'b0));
        chk("sb_addr",   64'(dmem_addr), 64'(30'h400));
        chk("sb_be",     64'(dmem_be),   64'(4'b1000));
        chk("sb_rdy1",   64'(exe_ready), 64'(1'b0));
        chk("sb_wbv1",   64'(wb_valid),  64'(1'b0));
        tick;
        chk("sb_rdy2",   64'(exe_ready), 64'(1'b0));
        chk("sb_req2",   64'(dmem_req),  64'(1'b1));
        tick;
        chk("sb_rdy3",   64'(exe_ready), 64'(1'b0));
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
        tick;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("sb_wbv",    64'(wb_valid),   64'(1'b1));
        chk("sb_bus",    64'(MEM_WB_BUS), 64'({1'b1, 5'd5, 32'hFFFF_FF80}));
        chk("sb_req_off",64'(dmem_req),   64'(1'b0));
        chk("sb_rdy4",   64'(exe_ready),  64'(1'b1));
        tick;
        chk("sb_wbv_end",64'(wb_valid),   64'(1'b0));

        // Half store at 0x2002, ack in the first request cycle
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 5'd6, 32'h0000_2002, 32'h1234_ABCD);
        tick;
        exe_valid = 1'b0;
        chk("hs_req",   64'(dmem_req),   64'(1'b1));
        chk("hs_we",    64'(dmem_we),    64'(1'b1));
        chk("hs_addr",  64'(dmem_addr),  64'(30'h800));
        chk("hs_be",    64'(dmem_be),    64'(4'b1100));
        chk("hs_wdata", 64'(dmem_wdata), 64'(32'hABCD_ABCD));
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        chk("hs_wbv",   64'(wb_valid),        64'(1'b1));
        chk("hs_wben",  64'(MEM_WB_BUS[37]),  64'(1'b0));
        chk("hs_data",  64'(MEM_WB_BUS[31:0]),64'(32'd0));
        chk("hs_req_off",64'(dmem_req),       64'(1'b0));

        // Misaligned word load at 0x0006, then an immediate pass-through op
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7, 32'h0000_0006, 32'h0);
        tick;
        chk("ma_aerr",  64'(align_err),        64'(1'b1));
        chk("ma_wbv",   64'(wb_valid),         64'(1'b1));
        chk("ma_wben",  64'(MEM_WB_BUS[37]),   64'(1'b0));
        chk("ma_data",  64'(MEM_WB_BUS[31:0]), 64'(32'd0));
        chk("ma_req",   64'(dmem_req),         64'(1'b0));
        chk("ma_ready", 64'(exe_ready),        64'(1'b1));
        EXE_MEM_BUS = mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd8, 32'h0, 32'h0000_0055);
        tick;
        exe_valid = 1'b0;
        chk("ma_next_wbv",  64'(wb_valid),   64'(1'b1));
        chk("ma_next_bus",  64'(MEM_WB_BUS), 64'({1'b1, 5'd8, 32'h0000_0055}));
        chk("ma_next_aerr", 64'(align_err),  64'(1'b0));

        // Word load at 0x8: data passes unmodified even with sign_ext set
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 5'd11, 32'h0000_0008, 32'h0);
        tick;
        exe_valid = 1'b0;
        chk("wl_be",   64'(dmem_be),   64'(4'b1111));
        chk("wl_addr", 64'(dmem_addr), 64'(30'h2));
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick;
        dmem_ack = 1'b0;
        chk("wl_bus",  64'(MEM_WB_BUS), 64'({1'b1, 5'd11, 32'hDEAD_BEEF}));

        // Reset while a word load is outstanding, then a late ack
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9, 32'h0000_0100, 32'h0);
        tick;
        exe_valid = 1'b0;
        chk("rm_req",  64'(dmem_req),  64'(1'b1));
        chk("rm_addr", 64'(dmem_addr), 64'(30'h40));
        tick;
        #2;
        resetn = 1'b0;
        #1;
        chk("rm_req_drop", 64'(dmem_req),  64'(1'b0));
        chk("rm_ready",    64'(exe_ready), 64'(1'b1));
        chk("rm_wbv",      64'(wb_valid),  64'(1'b0));
        @(negedge clk);
        resetn = 1'b1;
        tick;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        tick;
        dmem_ack = 1'b0;
        chk("rm_late_wbv",   64'(wb_valid),  64'(1'b0));
        chk("rm_late_req",   64'(dmem_req),  64'(1'b0));
        chk("rm_late_ready", 64'(exe_ready), 64'(1'b1));

        // Zero-extended half load at 0x0002
        exe_valid   = 1'b1;
        EXE_MEM_BUS = mk(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd10, 32'h0000_0002, 32'h0);
        tick;
        exe_valid = 1'b0;
        chk("zh_be",  64'(dmem_be), 64'(4'b1100));
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8001_0000;
        tick;
        dmem_ack = 1'b0;
        chk("zh_wbv", 64'(wb_valid),   64'(1'b1));
        chk("zh_bus", 64'(MEM_WB_BUS), 64'({1'b1, 5'd10, 32'h0000_8001}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
